// File: rtl/valve_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : valve_seq_pkg
// Purpose  : Shared types, valve index constants and opening priority for
//            the supply valve sequencer.
// Revision : 1.0  initial release
// ============================================================================
package valve_seq_pkg;

  // FSM state encoding, also exported on the debug port
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    STEADY = 2'd2
  } state_t;

  // Bit positions inside req/valve
  localparam logic [1:0] DFR = 2'd0;
  localparam logic [1:0] FR0 = 2'd1;
  localparam logic [1:0] FR1 = 2'd2;
  localparam logic [1:0] FR2 = 2'd3;

  // Opening priority, highest first
  localparam logic [1:0] PRIO_ORDER [4] = '{FR0, FR1, FR2, DFR};

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  // Highest-priority pending valve; walking from lowest to highest lets the
  // last hit win without a found-flag.
  function automatic pick_t pick_candidate(input logic [3:0] pend);
    pick_t p;
    p = '0;
    for (int k = 3; k >= 0; k--) begin
      if (pend[PRIO_ORDER[k]]) begin
        p.valid = 1'b1;
        p.idx   = PRIO_ORDER[k];
      end
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/valve_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : valve_sequencer_if
// Purpose  : Demand/drive bundle between the flow-level FSM (master) and the
//            valve sequencer (slave).
// Revision : 1.0  initial release
// ============================================================================
interface valve_sequencer_if;
  import valve_seq_pkg::*;

  logic       enable;
  logic [3:0] req;
  logic [3:0] valve;
  logic       busy;
  state_t     state;

  modport master (
    output enable,
    output req,
    input  valve,
    input  busy,
    input  state
  );

  modport slave (
    input  enable,
    input  req,
    output valve,
    output busy,
    output state
  );

endinterface
`default_nettype wire

// File: rtl/valve_hold_timer.sv
`default_nettype none
// ============================================================================
// Module   : valve_hold_timer
// Purpose  : Per-valve minimum-open-time down-counter. Loaded on opening,
//            saturates at zero; expired is high once the hold has elapsed.
// Revision : 1.0  initial release
// ============================================================================
module valve_hold_timer #(
  parameter int MIN_ON = 8
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic load,
  input  wire logic clear,
  output logic      expired
);

  localparam int              C_HW   = $clog2(MIN_ON) + 1;
  localparam logic [C_HW-1:0] C_LOAD = C_HW'(MIN_ON - 1);

  logic [C_HW-1:0] r_cnt;

  // Hold countdown: clear wins, then load, then saturating decrement
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= C_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - C_HW'(1);
    end
  end

  assign expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : valve_sequencer
// Purpose  : Staggers supply valve openings, enforces a minimum open time per
//            valve and offers an emergency close through enable.
// Revision : 1.0  initial release
// ============================================================================
module valve_sequencer
  import valve_seq_pkg::*;
#(
  parameter int STAGGER = 4,
  parameter int MIN_ON  = 8
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  valve_sequencer_if.slave  bus
);

  localparam int              C_SW   = $clog2(STAGGER) + 1;
  localparam logic [C_SW-1:0] C_SLOAD = C_SW'(STAGGER - 1);

  logic [C_SW-1:0] r_stagger;
  logic [3:0]      r_valve;
  state_t          r_state;

  logic [3:0]      w_pend;
  pick_t           w_pick;
  logic            w_open_ok;
  logic [3:0]      w_open_vec;
  logic [3:0]      w_close;
  logic [3:0]      w_expired;
  logic [3:0]      w_valve_nxt;
  state_t          w_state_nxt;
  logic            w_clear;

  assign w_clear = ~bus.enable;

  // One hold timer per valve, loaded on that valve's opening edge
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hold
      valve_hold_timer #(
        .MIN_ON (MIN_ON)
      ) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_open_vec[gi]),
        .clear   (w_clear),
        .expired (w_expired[gi])
      );
    end
  endgenerate

  // Next valve vector: at most one open (priority, stagger-gated), any closes
  always_comb begin
    w_pend      = bus.req & ~r_valve;
    w_pick      = pick_candidate(w_pend);
    w_open_ok   = w_pick.valid && (r_stagger == '0);
    w_open_vec  = w_open_ok ? (4'b0001 << w_pick.idx) : 4'b0000;
    w_close     = r_valve & ~bus.req & w_expired;
    w_valve_nxt = (r_valve & ~w_close) | w_open_vec;
    if (|(bus.req & ~w_valve_nxt)) begin
      w_state_nxt = RAMP;
    end else if (|w_valve_nxt) begin
      w_state_nxt = STEADY;
    end else begin
      w_state_nxt = IDLE;
    end
  end

  // Sequencer FSM: valve register, stagger counter and state, all registered
  always_ff @(posedge clk) begin
    if (!reset_n || !bus.enable) begin
      r_valve   <= 4'b0000;
      r_stagger <= '0;
      r_state   <= IDLE;
    end else begin
      r_valve <= w_valve_nxt;
      r_state <= w_state_nxt;
      if (w_open_ok) begin
        r_stagger <= C_SLOAD;
      end else if (r_stagger != '0) begin
        r_stagger <= r_stagger - C_SW'(1);
      end
    end
  end

  assign bus.valve = r_valve;
  assign bus.state = r_state;
  assign bus.busy  = (r_state == RAMP);

endmodule
`default_nettype wire
